mu0_core_p: RTL

Parametrised next-generation MU0 processor core. It uses a configurable data width and derives the address width from it, and runs an explicit fetch/execute state machine. Memory accesses use a request/acknowledge handshake, so memory may insert wait states. Beyond the base instruction set, it adds a load-immediate instruction, a halted status, illegal-opcode trapping and debug visibility of PC and ACC. It replaces the fixed 16-bit core at the top of the CPU hierarchy and connects directly to the memory model.

---
 rtl/mu0_pkg.sv | 29 ++
 rtl/mu0_alu_p.sv | 24 ++
 rtl/mu0_core_p.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the parametrised MU0 core: opcodes, FSM states, ALU functions.
package mu0_pkg;

  localparam int unsigned OP_LDA = 0;
  localparam int unsigned OP_STO = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_JMP = 4;
  localparam int unsigned OP_JGE = 5;
  localparam int unsigned OP_JNE = 6;
  localparam int unsigned OP_STP = 7;
  localparam int unsigned OP_LDI = 8;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM_RD,
    MEM_WR,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    PASS_B,
    ADD,
    SUB,
    INC
  } alu_fn_e;

endpackage

// File: rtl/mu0_alu_p.sv
// Combinational ALU shared by the accumulator datapath and the PC incrementer.
module mu0_alu_p
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_fn_e           fn,
  output logic [DATA_W-1:0] y_c
);

  always_comb begin
    y_c = b;
    unique case (fn)
      PASS_B:  y_c = b;
      ADD:     y_c = a + b;
      SUB:     y_c = a - b;
      INC:     y_c = a + DATA_W'(1);
      default: y_c = b;
    endcase
  end

endmodule

// File: rtl/mu0_core_p.sv
// Parametrised MU0 core with fetch/decode/execute FSM and req/ack memory handshake.
module mu0_core_p
  import mu0_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  localparam int unsigned ADDR_W = DATA_W - OP_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              memrq,
  output logic              rnw,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] s_field;
  alu_fn_e           acc_fn;
  logic [DATA_W-1:0] acc_b;
  logic [DATA_W-1:0] acc_y_c;
  logic [ADDR_W-1:0] pc_inc_c;

  assign opcode  = ir_q[DATA_W-1 -: OP_W];
  assign s_field = ir_q[ADDR_W-1:0];

  mu0_alu_p #(.DATA_W(DATA_W)) u_acc_alu (
    .a   (acc_q),
    .b   (acc_b),
    .fn  (acc_fn),
    .y_c (acc_y_c)
  );

  mu0_alu_p #(.DATA_W(ADDR_W)) u_pc_inc (
    .a   (pc_q),
    .b   ('0),
    .fn  (INC),
    .y_c (pc_inc_c)
  );

  // State and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      acc_q     <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    acc_fn    = PASS_B;
    acc_b     = mem_rdata;

    unique case (state_q)
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_inc_c;
          state_d = DECODE;
        end
      end

      DECODE: begin
        case (opcode)
          OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): state_d = MEM_RD;
          OP_W'(OP_STO): state_d = MEM_WR;
          OP_W'(OP_JMP): begin
            pc_d    = s_field;
            state_d = FETCH;
          end
          OP_W'(OP_JGE): begin
            if (!acc_q[DATA_W-1]) pc_d = s_field;
            state_d = FETCH;
          end
          OP_W'(OP_JNE): begin
            if (acc_q != '0) pc_d = s_field;
            state_d = FETCH;
          end
          OP_W'(OP_LDI): begin
            acc_b   = DATA_W'(s_field);
            acc_d   = acc_y_c;
            state_d = FETCH;
          end
          OP_W'(OP_STP): state_d = HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end
        endcase
      end

      MEM_RD: begin
        if (opcode == OP_W'(OP_ADD)) begin
          acc_fn = ADD;
        end else if (opcode == OP_W'(OP_SUB)) begin
          acc_fn = SUB;
        end
        if (mem_ack) begin
          acc_d   = acc_y_c;
          state_d = FETCH;
        end
      end

      MEM_WR: begin
        if (mem_ack) state_d = FETCH;
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  // Moore outputs; reset masks the request so an in-flight access is dropped at once
  assign memrq     = !rst && (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR);
  assign rnw       = (state_q != MEM_WR);
  assign mem_addr  = (state_q == FETCH) ? pc_q : s_field;
  assign mem_wdata = acc_q;
  assign halted    = (state_q == HALT);
  assign illegal   = illegal_q;
  assign pc_dbg    = pc_q;
  assign acc_dbg   = acc_q;

endmodule
